// File: rtl/pcie_tx_stream_buffer.sv
// pcie_tx_stream_buffer
//   Buffers application TX TLP words and drives the 75-bit TX streaming port of
//   the PCIe wrapper. Enforces packet framing, and holds non-posted TLPs at a
//   packet boundary while the core asserts tx_stream_mask0. Delivery is strictly
//   in order, so an NP packet held at the head blocks everything behind it.
//
//   Word layout: [74]=err [73]=sop [72]=eop [71:64]=rsvd [63:0]=data
//
// Ports
//   clk, srst          clock, synchronous active-high reset
//   app_tx_data/valid  upstream write port; app_tx_ready = !full
//   tx_stream_data0    word toward wrapper (zero when not valid)
//   tx_stream_valid0   word valid; tx_stream_ready0 accepts it
//   tx_stream_mask0    core forbids starting new NP TLPs
//   fill_level         FIFO occupancy, 0..DEPTH
//   np_stall           NP head held back by mask this cycle
//   proto_err          one-cycle pulse on a framing violation
//
// Optional build macro PCIE_TXBUF_STATS_EN adds saturating counters
//   pkt_cnt (delivered EOP words) and np_stall_cyc (cycles with np_stall=1).
module pcie_tx_stream_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          srst,
    input  logic [74:0]   app_tx_data,
    input  logic          app_tx_valid,
    output logic          app_tx_ready,
    output logic [74:0]   tx_stream_data0,
    output logic          tx_stream_valid0,
    input  logic          tx_stream_ready0,
    input  logic          tx_stream_mask0,
    output logic [AW:0]   fill_level,
    output logic          np_stall,
    output logic          proto_err
`ifdef PCIE_TXBUF_STATS_EN
    ,
    output logic [31:0]   pkt_cnt,
    output logic [31:0]   np_stall_cyc
`endif
);

    typedef enum logic {
        IDLE,
        PKT
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    state_t        state, state_nxt;
    logic [74:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          held, held_nxt;
    logic          push, pop, empty, full;
    logic [74:0]   head;
    logic          head_sop, head_eop, head_np;

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign app_tx_ready = !full;
    assign fill_level   = count;
    assign push         = app_tx_valid && app_tx_ready;

    assign head     = mem[rd_ptr];
    assign head_sop = head[73];
    assign head_eop = head[72];
    // DW0 = data[63:32]: fmt[1]=bit 62, type=bits 60:56
    assign head_np  = (!head[62] && head[60:57] == 4'b0000)
                   || (head[60:56] == 5'b00010)
                   || (head[60:57] == 4'b0010);

    assign tx_stream_data0 = tx_stream_valid0 ? head : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= app_tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state  <= IDLE;
            held   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            held  <= held_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // An SOP head already presented in IDLE stays presented even if mask rises
    // before it is accepted, so valid never drops without a pop.
    always_comb begin
        state_nxt        = state;
        held_nxt         = held;
        pop              = 1'b0;
        tx_stream_valid0 = 1'b0;
        np_stall         = 1'b0;
        proto_err        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    if (!head_sop) begin
                        // orphan word: dropped without being presented
                        pop       = 1'b1;
                        proto_err = 1'b1;
                    end else if (head_np && tx_stream_mask0 && !held) begin
                        np_stall = 1'b1;
                    end else begin
                        tx_stream_valid0 = 1'b1;
                        if (tx_stream_ready0) begin
                            pop      = 1'b1;
                            held_nxt = 1'b0;
                            if (!head_eop) begin
                                state_nxt = PKT;
                            end
                        end else begin
                            held_nxt = 1'b1;
                        end
                    end
                end
            end
            PKT: begin
                if (!empty) begin
                    tx_stream_valid0 = 1'b1;
                    if (tx_stream_ready0) begin
                        pop = 1'b1;
                        // SOP inside a packet: flagged once, when it is sent
                        proto_err = head_sop;
                        if (head_eop) begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef PCIE_TXBUF_STATS_EN
    always_ff @(posedge clk) begin
        if (srst) begin
            pkt_cnt      <= '0;
            np_stall_cyc <= '0;
        end else begin
            if (pop && tx_stream_valid0 && head_eop && pkt_cnt != '1) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
            if (np_stall && np_stall_cyc != '1) begin
                np_stall_cyc <= np_stall_cyc + 1'b1;
            end
        end
    end
`endif

endmodule
